truth_table_engine: RTL
=======================

TRUTH_TABLE_ENGINE -- requirements
Module: truth_table_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning input vector width, legal range 1..8.
REQ-002 SHALL have parameter INIT_TABLE, default 16'h8118 (width 2^N_IN), meaning reset table contents; bit i = output for input index i.
REQ-003 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load_start  in  1  begin serial table load.
- load_valid  in  1  load_bit is valid this cycle.
- load_bit  in  1  table bit for current load address.
- load_done  out  1  one-cycle pulse after the last table bit is written.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block accepts in_vec.
- in_vec  in  N_IN  vector to evaluate.
- sweep_start  in  1  begin exhaustive sweep.
- cnt_clr  in  1  clear match counter.
- out_valid  out  1  out_s/out_vec are valid.
- out_vec  out  N_IN  vector that produced out_s.
- out_s  out  1  table[out_vec].
- match_cnt  out  CNT_W  count of out_valid cycles with out_s=1.
- busy  out  1  state is not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD and SWEEP.
REQ-007 In IDLE, start priority SHALL be load_start > sweep_start > in_valid; the lower-priority request is ignored, not queued.
REQ-008 In IDLE, in_ready SHALL be 1; in LOAD and SWEEP, in_ready SHALL be 0.
REQ-009 An IDLE handshake (in_valid&in_ready) SHALL give, on the next cycle, out_valid=1, out_vec=in_vec and out_s=table[in_vec]; throughput is one vector per cycle.
REQ-010 Cycles without an accepted vector or sweep step SHALL give out_valid=0, with out_vec and out_s holding their last values.
REQ-011 IDLE+load_start SHALL enter LOAD with the address set to 0; each load_valid cycle writes table[addr]=load_bit and increments addr.
REQ-012 The write at addr=2^N_IN-1 SHALL return the FSM to IDLE and pulse load_done on the following cycle.
REQ-013 load_start asserted in LOAD SHALL reset addr to 0; bits already written are retained.
REQ-014 Evaluations SHALL NOT use a partially loaded table, since in_ready=0 throughout LOAD.
REQ-015 IDLE+sweep_start SHALL enter SWEEP; starting the next cycle, the block emits out_vec=0,1,...,2^N_IN-1, one per cycle with out_valid=1, then returns to IDLE. Total output is 2^N_IN cycles, with no gap and no wrap.
REQ-016 load_start and sweep_start SHALL be ignored in SWEEP; sweep_start SHALL be ignored in LOAD.
REQ-017 match_cnt SHALL increment on out_valid&out_s and saturate at 2^CNT_W-1.
REQ-018 cnt_clr SHALL set match_cnt to 0 on the next edge; cnt_clr with a simultaneous increment yields 0.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 rst_n=0 at a clock edge SHALL set state=IDLE, table=INIT_TABLE, addr=0, load_done=0, out_valid=0, out_vec=0, out_s=0, match_cnt=0; in_ready is 1 after reset.
REQ-021 Reset during LOAD or SWEEP SHALL abort the operation with no load_done pulse, and the table is restored to INIT_TABLE.

Configuration
REQ-022 Macro TTE_SWEEP_EN defined SHALL compile in the SWEEP state and sweep_start per REQ-015.
REQ-023 Without TTE_SWEEP_EN, the SWEEP state and the sweep counter SHALL be absent and sweep_start SHALL be ignored; all other behaviour is unchanged.

Structure
REQ-024 Package tte_pkg SHALL hold the FSM state enum and the default constants (N_IN, CNT_W, INIT_TABLE).
REQ-025 Table storage SHALL be sub-module tte_lut: 2^N_IN-bit register, one serial write port, one combinational read port, synchronous load of INIT_TABLE on reset.

Verification
REQ-026 Reset, then sweep_start (TTE_SWEEP_EN) -> 16 consecutive out_valid cycles, out_s=1 only at out_vec 3, 4, 8, 15; match_cnt=4; busy falls after the 16th output.
REQ-027 Load sixteen 1 bits -> load_done one cycle after the 16th write; then in_vec=4'b0101 -> out_s=1 next cycle.
REQ-028 Assert rst_n=0 after the 7th load bit -> state IDLE, no load_done pulse; in_vec=4'b0011 -> out_s=1 (INIT_TABLE restored).
REQ-029 Back-to-back in_valid with vectors 3, 5, 8, 15 -> out_s=1, 0, 1, 1 on four consecutive cycles; then load_start and in_valid together -> vector not accepted, LOAD entered.
REQ-030 CNT_W=2 with 5 matching evaluations -> match_cnt=3 (saturated); cnt_clr together with a match -> match_cnt=0.

Source files
------------

// File: rtl/tte_pkg.sv
// Shared types and defaults for the truth-table engine.
// TTE_SWEEP_EN adds the SWEEP state used by the exhaustive sweep.
package tte_pkg;

   localparam int          DEF_N_IN       = 4;
   localparam int          DEF_CNT_W      = 8;
   localparam logic [15:0] DEF_INIT_TABLE = 16'h8118;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD
`ifdef TTE_SWEEP_EN
      ,
      ST_SWEEP
`endif
   } state_e;

endpackage

// File: rtl/tte_lut.sv
// Truth-table storage: one serial write port, one combinational read port,
// reloaded with INIT_TABLE on synchronous reset.
module tte_lut
   import tte_pkg::*;
#(
   parameter int                     N_IN       = DEF_N_IN,
   parameter logic [(1<<N_IN)-1:0]   INIT_TABLE = DEF_INIT_TABLE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [N_IN-1:0] waddr_i,
   input  logic            wbit_i,
   input  logic [N_IN-1:0] raddr_i,
   output logic            rdata_o
);

   logic [(1<<N_IN)-1:0] tbl_q;

   always_ff @(posedge clk) begin
      if (!rst_n)    tbl_q          <= INIT_TABLE;
      else if (we_i) tbl_q[waddr_i] <= wbit_i;
   end

   assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/truth_table_engine.sv
// Programmable truth-table evaluator with serial load, match counter and,
// when TTE_SWEEP_EN is defined, an exhaustive input sweep.
module truth_table_engine
   import tte_pkg::*;
#(
   parameter int                     N_IN       = DEF_N_IN,
   parameter logic [(1<<N_IN)-1:0]   INIT_TABLE = DEF_INIT_TABLE,
   parameter int                     CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic             load_valid,
   input  logic             load_bit,
   output logic             load_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             sweep_start,
   input  logic             cnt_clr,
   output logic             out_valid,
   output logic [N_IN-1:0]  out_vec,
   output logic             out_s,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy
);

   localparam logic [N_IN-1:0] LAST = '1;

   state_e           state_q;
   logic [N_IN-1:0]  addr_q;
   logic             load_done_q;
   logic             out_valid_q;
   logic [N_IN-1:0]  out_vec_q;
   logic             out_s_q;
   logic [CNT_W-1:0] match_cnt_q;
   logic [N_IN-1:0]  raddr;
   logic             rd_bit;
   logic             we;

   assign we = (state_q == ST_LOAD) && load_valid && !load_start;

`ifdef TTE_SWEEP_EN
   logic [N_IN-1:0] sweep_q;
   // sweep_q rests at 0 in IDLE, so the first sweep step reads entry 0
   assign raddr = (state_q == ST_IDLE && !sweep_start) ? in_vec : sweep_q;
`else
   logic unused_sweep_start;
   assign unused_sweep_start = sweep_start;
   assign raddr = in_vec;
`endif

   tte_lut #(.N_IN(N_IN), .INIT_TABLE(INIT_TABLE)) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we),
      .waddr_i (addr_q),
      .wbit_i  (load_bit),
      .raddr_i (raddr),
      .rdata_o (rd_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         load_done_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_s_q     <= 1'b0;
         match_cnt_q <= '0;
`ifdef TTE_SWEEP_EN
         sweep_q     <= '0;
`endif
      end else begin
         load_done_q <= 1'b0;
         out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (load_start) begin
                  state_q <= ST_LOAD;
                  addr_q  <= '0;
               end
`ifdef TTE_SWEEP_EN
               else if (sweep_start) begin
                  state_q     <= ST_SWEEP;
                  out_valid_q <= 1'b1;
                  out_vec_q   <= sweep_q;
                  out_s_q     <= rd_bit;
                  sweep_q     <= sweep_q + 1'b1;
               end
`endif
               else if (in_valid) begin
                  out_valid_q <= 1'b1;
                  out_vec_q   <= in_vec;
                  out_s_q     <= rd_bit;
               end
            end
            ST_LOAD: begin
               // a restart rewinds the address; written bits stay in the LUT
               if (load_start) begin
                  addr_q <= '0;
               end else if (load_valid) begin
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LAST) begin
                     state_q     <= ST_IDLE;
                     load_done_q <= 1'b1;
                  end
               end
            end
`ifdef TTE_SWEEP_EN
            ST_SWEEP: begin
               out_valid_q <= 1'b1;
               out_vec_q   <= sweep_q;
               out_s_q     <= rd_bit;
               sweep_q     <= sweep_q + 1'b1;
               if (sweep_q == LAST) state_q <= ST_IDLE;
            end
`endif
            default: state_q <= ST_IDLE;
         endcase

         if (cnt_clr)
            match_cnt_q <= '0;
         else if (out_valid_q && out_s_q && match_cnt_q != '1)
            match_cnt_q <= match_cnt_q + 1'b1;
      end
   end

   assign load_done = load_done_q;
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_s     = out_s_q;
   assign match_cnt = match_cnt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
